sram_bus_arbiter: RTL
=====================

// Module: sram_bus_arbiter
// PURPOSE
// - Responder for the CPU's inst_sram/data_sram SRAM-like ports: decodes, routes and arbitrates them onto the base RAM and ext RAM.
// - Sits between mycpu_top and the board RAMs. Returns read data one cycle after each accepted request.
// - Raises cpu_stall when both ports need base RAM in the same cycle.
// PARAMETERS
// - BASE_LO  32'h8000_0000  first byte address of base RAM (4 MB window)
// - EXT_LO   32'h8040_0000  first byte address of ext RAM (4 MB window)
// - RAM_AW   20             word-address width of each RAM
// - CNT_ADDR 32'hBFD0_0400  MMIO address of the conflict counter (ARB_PERF_EN only)
// PORTS
// - clk              in   1   system clock
// - resetn           in   1   asynchronous active-low reset
// - inst_sram_en     in   1   fetch request
// - inst_sram_we     in   4   byte write enables (fetch: 0)
// - inst_sram_addr   in   32  fetch byte address
// - inst_sram_wdata  in   32  unused for fetch; routed if we!=0
// - inst_sram_rdata  out  32  fetch data, 1 cycle after accept
// - data_sram_en     in   1   data request
// - data_sram_we     in   4   byte write enables
// - data_sram_addr   in   32  data byte address
// - data_sram_wdata  in   32  store data
// - data_sram_rdata  out  32  load data, 1 cycle after accept
// - cpu_stall        out  1   this cycle's inst request not accepted; CPU must hold it
// - bus_err          out  1   1-cycle pulse: data access hit unmapped address
// - base_en/ext_en       out  1       RAM request
// - base_we/ext_we       out  4       RAM byte enables
// - base_addr/ext_addr   out  RAM_AW  RAM word address = byte_addr[RAM_AW+1:2]
// - base_wdata/ext_wdata out  32      RAM write data
// - base_rdata/ext_rdata in   32      RAM read data, valid 1 cycle after en
// BEHAVIOUR
// - Decode: inst port always targets base RAM.
//   - Data port: [BASE_LO, +4MB) -> BASE; [EXT_LO, +4MB) -> EXT; else -> NONE.
// - ext RAM: driven combinationally from the data port when target=EXT; never contended.
// - base RAM arbitration, FSM {S_NORM, S_IPRIO}:
//   - S_NORM, no conflict: the sole requester gets base RAM; stay S_NORM.
//   - S_NORM, conflict (inst_en and data->BASE): data wins; cpu_stall=1; next S_IPRIO.
//   - S_IPRIO: inst wins unconditionally. If data->BASE, that data request is dropped; the CPU data port has no stall and relies on the fetch stall ordering.
//     - If inst_en=0 in S_IPRIO, data is served normally.
//     - Always return to S_NORM.
//   - Result: no port waits more than 1 cycle; cpu_stall never asserts 2 cycles in a row.
// - Response select regs rsp_i, rsp_d in {NONE, BASE, EXT, CNT}, captured at each accept.
//   - Next cycle, rdata is muxed from the selected RAM, or the counter for CNT.
//   - NONE returns the last registered value, held in rdata hold regs.
// - Unmapped data: write dropped, read returns 32'h0, bus_err pulses the cycle after.
// - Writes: byte enables are passed through unchanged; any we!=0 with en=1 is a write.
// - Reset (async, resetn=0):
//   - State -> S_NORM; rsp_* -> NONE; rdata holds -> 0; bus_err=0.
//   - cpu_stall=0; all RAM en/we gated to 0 while resetn=0.
// - Reset mid-transaction: any in-flight response is discarded; no RAM write issues during reset.
// CONFIGURATION
// - ARB_PERF_EN defined: 32-bit conflict counter, +1 per cycle with cpu_stall=1, wraps at 2^32.
//   - Data read at CNT_ADDR returns it; a write clears it. Reset value 0.
// - ARB_PERF_EN undefined: no counter; CNT_ADDR decodes as NONE (unmapped).
// STRUCTURE
// - Package sram_arb_pkg: target enum {NONE, BASE, EXT, CNT}; FSM state enum; default window constants.
// - Sub-module sram_addr_decode: combinational byte address -> target; instantiated for the data port.
// TESTING
// - Fetch 0x8000_0010 alone, base_rdata=0x1234_5678 -> inst_sram_rdata=0x1234_5678 next cycle, cpu_stall=0.
// - Store we=4'b0011 to 0x8040_0004 -> ext_en=1, ext_we=4'b0011, ext_addr=1, same cycle.
// - Fetch plus load 0x8000_0100 every cycle for 6 cycles -> cpu_stall pattern 1,0,1,0,1,0.
//   - Data served on stalled cycles; inst served on the others.
// - Load from 0x9000_0000 -> no RAM en, data_sram_rdata=0 and bus_err=1 next cycle.
// - Reset asserted while a base read is in flight -> base_en=0 immediately.
//   - After release: inst_sram_rdata=0, state S_NORM.
// - ARB_PERF_EN: 3 conflicts, then load CNT_ADDR -> 3; store CNT_ADDR, then load -> 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default address windows for the CPU SRAM-port arbiter.
// Window sizes are fixed at 4 MB per RAM; the counter address is used only with ARB_PERF_EN.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BASE = 2'd1,
    EXT  = 2'd2,
    CNT  = 2'd3
  } target_t;

  typedef enum logic {
    S_NORM  = 1'b0,
    S_IPRIO = 1'b1
  } arb_state_t;

  localparam logic [31:0] BASE_LO_DEF  = 32'h8000_0000;
  localparam logic [31:0] EXT_LO_DEF   = 32'h8040_0000;
  localparam logic [31:0] CNT_ADDR_DEF = 32'hBFD0_0400;
  localparam logic [31:0] WIN_BYTES    = 32'h0040_0000;
  localparam int          RAM_AW_DEF   = 20;

endpackage

// File: rtl/sram_addr_decode.sv
// Byte address -> target decode for the data port.
// The CNT target exists only when ARB_PERF_EN is defined; otherwise CNT_ADDR is unmapped.
module sram_addr_decode
  import sram_arb_pkg::*;
#(
  parameter logic [31:0] BASE_LO  = BASE_LO_DEF,
  parameter logic [31:0] EXT_LO   = EXT_LO_DEF,
  parameter logic [31:0] CNT_ADDR = CNT_ADDR_DEF
) (
  input  logic [31:0] addr,
  output target_t     target
);

  logic [31:0] base_off;
  logic [31:0] ext_off;

  // Offset compare keeps the window test correct for any window alignment.
  assign base_off = addr - BASE_LO;
  assign ext_off  = addr - EXT_LO;

  always_comb begin
    target = NONE;
    if (base_off < WIN_BYTES) begin
      target = BASE;
    end else if (ext_off < WIN_BYTES) begin
      target = EXT;
`ifdef ARB_PERF_EN
    end else if (addr == CNT_ADDR) begin
      target = CNT;
`else
    end else if (addr == CNT_ADDR) begin
      target = NONE;
`endif
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Routes the CPU inst/data SRAM ports onto base and ext RAM, arbitrating base RAM.
// Define ARB_PERF_EN to add a memory-mapped base-RAM conflict counter at CNT_ADDR.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [31:0] BASE_LO  = BASE_LO_DEF,
  parameter logic [31:0] EXT_LO   = EXT_LO_DEF,
  parameter int          RAM_AW   = RAM_AW_DEF,
  parameter logic [31:0] CNT_ADDR = CNT_ADDR_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_we,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              cpu_stall,
  output logic              bus_err,
  output logic              base_en,
  output logic [3:0]        base_we,
  output logic [RAM_AW-1:0] base_addr,
  output logic [31:0]       base_wdata,
  input  logic [31:0]       base_rdata,
  output logic              ext_en,
  output logic [3:0]        ext_we,
  output logic [RAM_AW-1:0] ext_addr,
  output logic [31:0]       ext_wdata,
  input  logic [31:0]       ext_rdata
);

  target_t    data_tgt;
  arb_state_t state_reg, state_next;
  target_t    rsp_i_reg, rsp_d_reg, rsp_d_next;
  logic [31:0] hold_i_reg, hold_d_reg;
  logic        err_reg;
  logic [31:0] cnt_val;

  logic data_base, conflict, grant_inst, grant_data, stall_raw, data_unmapped;

  sram_addr_decode #(
    .BASE_LO  (BASE_LO),
    .EXT_LO   (EXT_LO),
    .CNT_ADDR (CNT_ADDR)
  ) u_data_decode (
    .addr   (data_sram_addr),
    .target (data_tgt)
  );

  assign data_base     = data_sram_en && (data_tgt == BASE);
  assign conflict      = inst_sram_en && data_base;
  assign data_unmapped = data_sram_en && (data_tgt == NONE);

  // Alternating priority: data wins a conflict, then inst wins the very next cycle.
  always_comb begin
    state_next = S_NORM;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    stall_raw  = 1'b0;
    case (state_reg)
      S_NORM: begin
        if (conflict) begin
          grant_data = 1'b1;
          stall_raw  = 1'b1;
          state_next = S_IPRIO;
        end else begin
          grant_inst = inst_sram_en;
          grant_data = data_base;
        end
      end
      S_IPRIO: begin
        grant_inst = inst_sram_en;
        grant_data = data_base && !inst_sram_en;
      end
      default: state_next = S_NORM;
    endcase
  end

  assign cpu_stall = stall_raw && resetn;

  // Base RAM port: inst takes it when granted, otherwise the data port.
  always_comb begin
    base_en    = resetn && (grant_inst || grant_data);
    base_we    = 4'b0000;
    base_addr  = data_sram_addr[RAM_AW+1:2];
    base_wdata = data_sram_wdata;
    if (grant_inst) begin
      base_addr  = inst_sram_addr[RAM_AW+1:2];
      base_wdata = inst_sram_wdata;
      if (resetn) base_we = inst_sram_we;
    end else if (grant_data && resetn) begin
      base_we = data_sram_we;
    end
  end

  assign ext_en    = resetn && data_sram_en && (data_tgt == EXT);
  assign ext_we    = ext_en ? data_sram_we : 4'b0000;
  assign ext_addr  = data_sram_addr[RAM_AW+1:2];
  assign ext_wdata = data_sram_wdata;

  always_comb begin
    rsp_d_next = NONE;
    if (data_sram_en) begin
      case (data_tgt)
        BASE:    rsp_d_next = grant_data ? BASE : NONE;
        EXT:     rsp_d_next = EXT;
        CNT:     rsp_d_next = CNT;
        default: rsp_d_next = NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= S_NORM;
      rsp_i_reg  <= NONE;
      rsp_d_reg  <= NONE;
      hold_i_reg <= 32'h0;
      hold_d_reg <= 32'h0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rsp_i_reg  <= grant_inst ? BASE : NONE;
      rsp_d_reg  <= rsp_d_next;
      hold_i_reg <= inst_sram_rdata;
      hold_d_reg <= data_sram_rdata;
      err_reg    <= data_unmapped;
    end
  end

  assign inst_sram_rdata = (rsp_i_reg == BASE) ? base_rdata : hold_i_reg;
  assign bus_err         = err_reg;

  // An unmapped access reads as zero, which then becomes the held value.
  always_comb begin
    data_sram_rdata = hold_d_reg;
    if (err_reg) begin
      data_sram_rdata = 32'h0;
    end else begin
      case (rsp_d_reg)
        BASE:    data_sram_rdata = base_rdata;
        EXT:     data_sram_rdata = ext_rdata;
        CNT:     data_sram_rdata = cnt_val;
        default: data_sram_rdata = hold_d_reg;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  logic [31:0] cnt_reg;
  logic        cnt_wr;

  assign cnt_wr = data_sram_en && (data_tgt == CNT) && (data_sram_we != 4'b0000);

  // A clearing write takes precedence over a same-cycle increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= 32'h0;
    end else if (cnt_wr) begin
      cnt_reg <= 32'h0;
    end else if (cpu_stall) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign cnt_val = cnt_reg;
`else
  assign cnt_val = 32'h0;
`endif

endmodule
